// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and arrow-key lookup for the PS/2 scancode decoder.
package ps2_pkg;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_00 = 8'h00;
    localparam logic [7:0] CODE_FF = 8'hFF;

    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    // One-hot position of an arrow code within KEYS_HELD; zero for any other code.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        case (code)
            CODE_LEFT:  m = 4'b0001;
            CODE_RIGHT: m = 4'b0010;
            CODE_UP:    m = 4'b0100;
            CODE_DOWN:  m = 4'b1000;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Inter-byte timeout: counts cycles while a prefix is pending, pulses expire at the terminal count.
module ps2_timeout_ctr
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire = run && (cnt_q == TERM);
        cnt_d  = cnt_q;
        if (clear || !run || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key events, with extended-arrow held state and an error counter.
//
// state   | meaning
// IDLE    | no prefix pending
// EXT     | E0 received, waiting for key or F0
// BRK     | F0 received, waiting for released key
// EXT_BRK | E0 F0 received, waiting for released extended key
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CODE_VALID,
    input  logic [7:0] CODE,
    input  logic       CODE_ERR,
    output logic       EVT_VALID,
    output logic [7:0] EVT_CODE,
    output logic       EVT_EXT,
    output logic       EVT_BREAK,
    output logic [3:0] KEYS_HELD,
    output logic [7:0] ERR_CNT
);

    ps2_state_e state_q, state_d;
    logic       evt_valid_q, evt_valid_d;
    logic [7:0] evt_code_q, evt_code_d;
    logic       evt_ext_q, evt_ext_d;
    logic       evt_break_q, evt_break_d;
    logic [3:0] keys_q, keys_d;
    logic [7:0] err_q, err_d;

    logic       expire;
    logic       fire, fire_ext, fire_brk, err_inc;
    logic       bad_byte, is_prefix;
    logic [3:0] mask;

    ps2_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (CLK),
        .rst   (RST),
        .clear (CODE_VALID),
        .run   (state_q != IDLE),
        .expire(expire)
    );

    always_comb begin
        state_d  = state_q;
        fire     = 1'b0;
        fire_ext = 1'b0;
        fire_brk = 1'b0;
        err_inc  = 1'b0;

        bad_byte  = CODE_ERR || (CODE == CODE_00) || (CODE == CODE_FF);
        is_prefix = (CODE == CODE_E0) || (CODE == CODE_F0);

        // A byte arriving in the expiry cycle takes priority; the timeout is simply dropped.
        if (CODE_VALID) begin
            if (bad_byte) begin
                err_inc = 1'b1;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (CODE == CODE_E0)      state_d = EXT;
                        else if (CODE == CODE_F0) state_d = BRK;
                        else                      fire = 1'b1;
                    end
                    EXT: begin
                        if (CODE == CODE_F0) begin
                            state_d = EXT_BRK;
                        end else if (CODE == CODE_E0) begin
                            state_d = EXT;
                        end else begin
                            fire     = 1'b1;
                            fire_ext = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    BRK: begin
                        state_d = IDLE;
                        if (is_prefix) begin
                            err_inc = 1'b1;
                        end else begin
                            fire     = 1'b1;
                            fire_brk = 1'b1;
                        end
                    end
                    EXT_BRK: begin
                        state_d = IDLE;
                        if (is_prefix) begin
                            err_inc = 1'b1;
                        end else begin
                            fire     = 1'b1;
                            fire_ext = 1'b1;
                            fire_brk = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (expire) begin
            err_inc = 1'b1;
            state_d = IDLE;
        end

        mask = fire_ext ? arrow_mask(CODE) : 4'b0000;

        evt_valid_d = 1'b0;
        evt_code_d  = evt_code_q;
        evt_ext_d   = evt_ext_q;
        evt_break_d = evt_break_q;
        keys_d      = keys_q;

        if (fire) begin
            if (fire_brk || !SUPPRESS_REPEAT || ((keys_q & mask) == 4'b0000)) begin
                evt_valid_d = 1'b1;
                evt_code_d  = CODE;
                evt_ext_d   = fire_ext;
                evt_break_d = fire_brk;
                keys_d      = fire_brk ? (keys_q & ~mask) : (keys_q | mask);
            end
        end

        err_d = err_q;
        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 8'h00;
            evt_ext_q   <= 1'b0;
            evt_break_q <= 1'b0;
            keys_q      <= 4'b0000;
            err_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_ext_q   <= evt_ext_d;
            evt_break_q <= evt_break_d;
            keys_q      <= keys_d;
            err_q       <= err_d;
        end
    end

    assign EVT_VALID = evt_valid_q;
    assign EVT_CODE  = evt_code_q;
    assign EVT_EXT   = evt_ext_q;
    assign EVT_BREAK = evt_break_q;
    assign KEYS_HELD = keys_q;
    assign ERR_CNT   = err_q;

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the CLK cycles allowed between a prefix byte and its follow-up byte.
REQ-002 SHALL have parameter SUPPRESS_REPEAT, default 1, meaning typematic make events of tracked keys are suppressed when 1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  board clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 CODE_VALID  input  1  single-cycle strobe: one received PS/2 data byte.
REQ-007 CODE  input  8  received byte, valid only with CODE_VALID.
REQ-008 CODE_ERR  input  1  parity/framing error flag, valid only with CODE_VALID.
REQ-009 EVT_VALID  output  1  single-cycle strobe: decoded key event.
REQ-010 EVT_CODE  output  8  key code of event (prefixes stripped).
REQ-011 EVT_EXT  output  1  1 = event was E0-prefixed.
REQ-012 EVT_BREAK  output  1  1 = release, 0 = press.
REQ-013 KEYS_HELD  output  4  level held-state of extended arrows: [0] left E0 6B, [1] right E0 74, [2] up E0 75, [3] down E0 72.
REQ-014 ERR_CNT  output  8  saturating count of dropped bytes and protocol errors.

Function
REQ-015 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-016 IDLE: E0 -> EXT; F0 -> BRK; other code -> make event, EXT_EXT=0, stay IDLE.
REQ-017 EXT: F0 -> EXT_BRK; E0 -> stay EXT, no error; other -> make event, EVT_EXT=1, -> IDLE.
REQ-018 BRK: non-prefix code -> break event, EVT_EXT=0, -> IDLE; E0 or F0 -> ERR_CNT+1, no event, -> IDLE.
REQ-019 EXT_BRK: non-prefix code -> break event, EVT_EXT=1, -> IDLE; E0 or F0 -> ERR_CNT+1, no event, -> IDLE.
REQ-020 CODE_VALID with CODE_ERR=1 SHALL drop the byte, ERR_CNT+1, FSM -> IDLE, no event, regardless of state.
REQ-021 Codes 00 and FF (keyboard overrun) SHALL be dropped like REQ-020; all other codes (incl. AA, E1) are ordinary codes.
REQ-022 Event outputs SHALL be registered: EVT_VALID high exactly one cycle, the cycle after the final byte's CODE_VALID; EVT_CODE/EXT/BREAK hold until next event.
REQ-023 KEYS_HELD bit SHALL set on make and clear on break of its extended arrow, updated in the same cycle EVT_VALID rises; non-extended 6B/74/75/72 do not affect it.
REQ-024 With SUPPRESS_REPEAT=1, a make of a tracked key whose KEYS_HELD bit is already 1 SHALL produce no event; untracked keys always emit.
REQ-025 Timeout counter SHALL clear on every CODE_VALID and count while state is not IDLE; on reaching TIMEOUT_CYCLES-1 FSM -> IDLE, ERR_CNT+1, no event.
REQ-026 CODE_VALID in the same cycle as timeout expiry SHALL be processed normally; the timeout is discarded.
REQ-027 ERR_CNT SHALL saturate at 255; multiple error causes in one cycle count once.
REQ-028 CODE_VALID on consecutive cycles SHALL be accepted without loss (one byte per cycle throughput).

Reset
REQ-029 RST SHALL force: state IDLE, timeout counter 0, EVT_VALID 0, EVT_CODE 00, EVT_EXT 0, EVT_BREAK 0, KEYS_HELD 0, ERR_CNT 0.
REQ-030 RST SHALL override any simultaneous CODE_VALID or timeout; a prefix in flight is discarded without error count.

Structure
REQ-031 Package ps2_pkg SHALL hold constants E0, F0, 00, FF, arrow codes 6B/74/75/72, and the FSM state type.
REQ-032 Timeout counter SHALL be sub-module ps2_timeout_ctr (inputs clear, run; output expire), width clog2(TIMEOUT_CYCLES).

Verification
REQ-033 Bytes 1C -> one cycle later EVT_VALID=1, EVT_CODE=1C, EXT=0, BREAK=0.
REQ-034 Bytes E0,74 then E0,F0,74 -> make EXT=1 sets KEYS_HELD=0010; break EXT=1 BREAK=1 clears to 0000.
REQ-035 E0,6B repeated three times (SUPPRESS_REPEAT=1) -> exactly one event; KEYS_HELD=0001.
REQ-036 F0 then 1C with CODE_ERR=1 -> no event, ERR_CNT=1, state IDLE; next 1C -> make event.
REQ-037 E0 then idle TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 in bench) -> ERR_CNT=1; following 74 -> make EXT=0.
REQ-038 E0,F0 then RST mid-sequence, then 74 -> make EXT=0, ERR_CNT=0; 300 CODE_ERR bytes -> ERR_CNT=255.
